// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared constants and state encoding for the ALU source sequencer
package alu_seq_pkg;

  localparam int NUM_GROUPS  = 4;
  localparam int GROUP_LANES = 16;
  localparam int WF_LANES    = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/exec_group_scan.sv
// rtl/exec_group_scan.sv - per-slice activity of an exec mask and lookahead for active slices above the current one
module exec_group_scan
  import alu_seq_pkg::*;
(
  input  logic [WF_LANES-1:0]   exec,
  input  logic [1:0]            group,
  output logic [NUM_GROUPS-1:0] act,
  output logic                  act_cur,
  output logic                  more
);

  always_comb begin
    act  = '0;
    more = 1'b0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      act[g] = |exec[g*GROUP_LANES +: GROUP_LANES];
    end
    // Only slices strictly above the current one decide whether another step is needed.
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (g > int'(group)) more = more | act[g];
    end
    act_cur = act[group];
  end

endmodule

// File: rtl/alu_src_sequencer.sv
// rtl/alu_src_sequencer.sv - steps one wavefront instruction through the ALU in 16-lane slices, skipping trailing idle slices
module alu_src_sequencer
  import alu_seq_pkg::*;
#(
  parameter int TAG_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [WF_LANES-1:0] issue_exec,
  input  logic [TAG_W-1:0]    issue_tag,
  output logic                src_buffer_wr_en,
  output logic                src_buffer_shift_en,
  input  logic                alu_stall,
  output logic                alu_valid,
  output logic [1:0]          alu_group,
  output logic                alu_first,
  output logic                alu_last,
  output logic [TAG_W-1:0]    alu_tag,
  output logic                seq_done,
  output logic                busy
);

  seq_state_e          state_q, state_d;
  logic [1:0]          group_q, group_d;
  logic [WF_LANES-1:0] exec_q, exec_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                seen_q, seen_d;

  logic [NUM_GROUPS-1:0] act;
  logic                  act_cur;
  logic                  more;

  exec_group_scan u_scan (
    .exec    (exec_q),
    .group   (group_q),
    .act     (act),
    .act_cur (act_cur),
    .more    (more)
  );

  logic run;
  logic advance;
  logic final_slice;
  logic accept;

  always_comb begin
    run         = (state_q == ST_RUN) && !rst;
    advance     = run && !alu_stall;
    final_slice = advance && !more;
    issue_ready = !rst && ((state_q == ST_IDLE) || final_slice);
    accept      = issue_valid && issue_ready;

    src_buffer_wr_en    = accept;
    src_buffer_shift_en = advance && more;
    seq_done            = final_slice;
    busy                = run;
    alu_valid           = run && act_cur;
    alu_first           = run && act_cur && !seen_q;
    alu_last            = run && act_cur && !more;
    alu_group           = run ? group_q : 2'd0;
    alu_tag             = run ? tag_q : '0;
  end

  always_comb begin
    state_d = state_q;
    group_d = group_q;
    exec_d  = exec_q;
    tag_d   = tag_q;
    seen_d  = seen_q;
    if (accept) begin
      // Accepting in the final cycle of the previous instruction gives zero-bubble back-to-back issue.
      state_d = ST_RUN;
      group_d = 2'd0;
      exec_d  = issue_exec;
      tag_d   = issue_tag;
      seen_d  = 1'b0;
    end else if (advance) begin
      if (more) begin
        group_d = group_q + 2'd1;
        seen_d  = seen_q | act_cur;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      group_q <= 2'd0;
      exec_q  <= '0;
      tag_q   <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      group_q <= group_d;
      exec_q  <= exec_d;
      tag_q   <= tag_d;
      seen_q  <= seen_d;
    end
  end

endmodule

// File: tb/tb_alu_src_sequencer.sv
// tb/tb_alu_src_sequencer.sv - directed cycle-by-cycle checks of the ALU source sequencer
module tb_alu_src_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [63:0] issue_exec;
  logic [5:0]  issue_tag;
  logic        src_buffer_wr_en;
  logic        src_buffer_shift_en;
  logic        alu_stall;
  logic        alu_valid;
  logic [1:0]  alu_group;
  logic        alu_first;
  logic        alu_last;
  logic [5:0]  alu_tag;
  logic        seq_done;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] FULL = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  alu_src_sequencer #(.TAG_W(6)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .issue_valid         (issue_valid),
    .issue_ready         (issue_ready),
    .issue_exec          (issue_exec),
    .issue_tag           (issue_tag),
    .src_buffer_wr_en    (src_buffer_wr_en),
    .src_buffer_shift_en (src_buffer_shift_en),
    .alu_stall           (alu_stall),
    .alu_valid           (alu_valid),
    .alu_group           (alu_group),
    .alu_first           (alu_first),
    .alu_last            (alu_last),
    .alu_tag             (alu_tag),
    .seq_done            (seq_done),
    .busy                (busy)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (rdy,wr,sh,v,grp2,f,l,tag6,done,busy)", tag, got, exp);
    end
  endtask

  // Inputs are already driven for this cycle; sample mid-cycle, then move to the next negedge.
  task automatic cyc(input string nm, input bit rdy, input bit wr, input bit sh, input bit v,
                     input logic [1:0] g, input bit f, input bit l, input logic [5:0] tg,
                     input bit d, input bit b);
    #1;
    check(nm,
          {issue_ready, src_buffer_wr_en, src_buffer_shift_en, alu_valid, alu_group,
           alu_first, alu_last, alu_tag, seq_done, busy},
          {rdy, wr, sh, v, g, f, l, tg, d, b});
    @(negedge clk);
  endtask

  task automatic offer(input logic [63:0] ex, input logic [5:0] tg);
    issue_valid = 1'b1;
    issue_exec  = ex;
    issue_tag   = tg;
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_exec = '0; issue_tag = '0; alu_stall = 1'b0;
    @(negedge clk);
    cyc("rst0", 0,0,0,0, 2'd0, 0,0, 6'd0, 0,0);
    issue_valid = 1'b1;
    cyc("rst1_valid", 0,0,0,0, 2'd0, 0,0, 6'd0, 0,0);
    issue_valid = 1'b0; rst = 1'b0;
    cyc("idle", 1,0,0,0, 2'd0, 0,0, 6'd0, 0,0);

    // full exec
    offer(FULL, 6'd5);
    cyc("full_T",  1,1,0,0, 2'd0, 0,0, 6'd0, 0,0);
    issue_valid = 1'b0;
    cyc("full_g0", 0,0,1,1, 2'd0, 1,0, 6'd5, 0,1);
    cyc("full_g1", 0,0,1,1, 2'd1, 0,0, 6'd5, 0,1);
    cyc("full_g2", 0,0,1,1, 2'd2, 0,0, 6'd5, 0,1);
    cyc("full_g3", 1,0,0,1, 2'd3, 0,1, 6'd5, 1,1);
    cyc("full_idle", 1,0,0,0, 2'd0, 0,0, 6'd0, 0,0);

    // only slice 1 active: early termination
    offer(64'h0000_0000_FFFF_0000, 6'd9);
    cyc("s1_T",  1,1,0,0, 2'd0, 0,0, 6'd0, 0,0);
    issue_valid = 1'b0;
    cyc("s1_g0", 0,0,1,0, 2'd0, 0,0, 6'd9, 0,1);
    cyc("s1_g1", 1,0,0,1, 2'd1, 1,1, 6'd9, 1,1);
    cyc("s1_idle", 1,0,0,0, 2'd0, 0,0, 6'd0, 0,0);

    // all-zero exec, offered while stalled in IDLE
    offer(64'h0, 6'd3); alu_stall = 1'b1;
    cyc("z_T_stall", 1,1,0,0, 2'd0, 0,0, 6'd0, 0,0);
    issue_valid = 1'b0; alu_stall = 1'b0;
    cyc("z_g0", 1,0,0,0, 2'd0, 0,0, 6'd3, 1,1);
    cyc("z_idle", 1,0,0,0, 2'd0, 0,0, 6'd0, 0,0);

    // back-to-back full instructions
    offer(FULL, 6'd1);
    cyc("bb_T",  1,1,0,0, 2'd0, 0,0, 6'd0, 0,0);
    cyc("bb_a0", 0,0,1,1, 2'd0, 1,0, 6'd1, 0,1);
    cyc("bb_a1", 0,0,1,1, 2'd1, 0,0, 6'd1, 0,1);
    cyc("bb_a2", 0,0,1,1, 2'd2, 0,0, 6'd1, 0,1);
    issue_tag = 6'd2;
    cyc("bb_a3", 1,1,0,1, 2'd3, 0,1, 6'd1, 1,1);
    issue_valid = 1'b0;
    cyc("bb_b0", 0,0,1,1, 2'd0, 1,0, 6'd2, 0,1);
    cyc("bb_b1", 0,0,1,1, 2'd1, 0,0, 6'd2, 0,1);
    cyc("bb_b2", 0,0,1,1, 2'd2, 0,0, 6'd2, 0,1);
    cyc("bb_b3", 1,0,0,1, 2'd3, 0,1, 6'd2, 1,1);
    cyc("bb_idle", 1,0,0,0, 2'd0, 0,0, 6'd0, 0,0);

    // 3-cycle stall at group 1; offered instruction must not be taken while stalled
    offer(FULL, 6'd7);
    cyc("st_T",  1,1,0,0, 2'd0, 0,0, 6'd0, 0,0);
    issue_valid = 1'b0;
    cyc("st_g0", 0,0,1,1, 2'd0, 1,0, 6'd7, 0,1);
    alu_stall = 1'b1; offer(FULL, 6'd8);
    cyc("st_hold1", 0,0,0,1, 2'd1, 0,0, 6'd7, 0,1);
    cyc("st_hold2", 0,0,0,1, 2'd1, 0,0, 6'd7, 0,1);
    cyc("st_hold3", 0,0,0,1, 2'd1, 0,0, 6'd7, 0,1);
    alu_stall = 1'b0; issue_valid = 1'b0;
    cyc("st_g1", 0,0,1,1, 2'd1, 0,0, 6'd7, 0,1);
    cyc("st_g2", 0,0,1,1, 2'd2, 0,0, 6'd7, 0,1);
    cyc("st_g3", 1,0,0,1, 2'd3, 0,1, 6'd7, 1,1);
    cyc("st_idle", 1,0,0,0, 2'd0, 0,0, 6'd0, 0,0);

    // reset at group 2 abandons the instruction
    offer(FULL, 6'd4);
    cyc("rr_T",  1,1,0,0, 2'd0, 0,0, 6'd0, 0,0);
    issue_valid = 1'b0;
    cyc("rr_g0", 0,0,1,1, 2'd0, 1,0, 6'd4, 0,1);
    cyc("rr_g1", 0,0,1,1, 2'd1, 0,0, 6'd4, 0,1);
    rst = 1'b1;
    cyc("rr_rst", 0,0,0,0, 2'd0, 0,0, 6'd0, 0,0);
    rst = 1'b0; offer(64'h0000_FFFF_0000_0000, 6'd6);
    cyc("rr_acc", 1,1,0,0, 2'd0, 0,0, 6'd0, 0,0);
    issue_valid = 1'b0;
    cyc("rr_n0", 0,0,1,0, 2'd0, 0,0, 6'd6, 0,1);
    cyc("rr_n1", 0,0,1,0, 2'd1, 0,0, 6'd6, 0,1);
    cyc("rr_n2", 1,0,0,1, 2'd2, 1,1, 6'd6, 1,1);
    cyc("rr_idle", 1,0,0,0, 2'd0, 0,0, 6'd0, 0,0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_src_sequencer.md
# alu_src_sequencer

Sequences the ALU source shift register for one SIMD/SIMF ALU: accepts one 64-lane wavefront instruction at a time, issues the load strobe, then steps the 16-lane slices through the ALU with per-slice valid, first/last flags and completion. Slices with zero exec bits are presented with no valid, and trailing all-zero slices are not stepped at all, so the instruction terminates early. It sits between issue/operand-collect (upstream) and `src_shift_reg` plus the ALU pipe (downstream).

## Interface
Parameters:
- `TAG_W`, 6: width of the opaque instruction tag carried to the ALU.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `issue_valid`  in  1  instruction with collected operands is offered.
- `issue_ready`  out  1  sequencer can accept this cycle.
- `issue_exec`  in  64  exec mask of the offered instruction.
- `issue_tag`  in  TAG_W  tag of the offered instruction.
- `src_buffer_wr_en`  out  1  load strobe to the shift register.
- `src_buffer_shift_en`  out  1  advance strobe to the shift register.
- `alu_stall`  in  1  downstream hold; freezes sequencing.
- `alu_valid`  out  1  current slice has at least one active lane.
- `alu_group`  out  2  slice index presented (0 = lanes 15:0).
- `alu_first`  out  1  first valid slice of the instruction.
- `alu_last`  out  1  last valid slice of the instruction.
- `alu_tag`  out  TAG_W  tag of the instruction in flight.
- `seq_done`  out  1  one-cycle pulse: instruction fully sequenced.
- `busy`  out  1  state is RUN.

## Operation
- States: IDLE, RUN. Registers: state, group (2b), exec copy (64b), tag, `seen_valid` flag.
- Per-slice activity `act[g] = |exec[16g+15:16g]`. `more = |act[3:group+1]` (0 when group = 3).
- Acceptance: `issue_valid && issue_ready`. `issue_ready = !rst && (IDLE || final)`, where `final = RUN && !alu_stall && !more`.
- On acceptance: `src_buffer_wr_en = 1` (combinational, same cycle). The register captures exec/tag, sets group = 0, clears `seen_valid`, and goes to RUN.
- RUN, per cycle:
  - `alu_valid = act[group]`.
  - `alu_first = act[group] && !seen_valid`.
  - `alu_last = act[group] && !more`.
- RUN, not stalled, `more = 1`: `src_buffer_shift_en = 1`, group += 1, `seen_valid |= act[group]`.
- RUN, not stalled, `more = 0`: `seq_done = 1`. Next state is RUN with the new instruction if one is accepted the same cycle, otherwise IDLE. No shift is issued.
- `src_buffer_wr_en` and `src_buffer_shift_en` are never asserted together.
- All-zero exec: one RUN cycle at group 0 with `alu_valid = 0` and `seq_done = 1`.
- Stall in RUN: all registers and outputs hold. Both strobes are 0 and `seq_done` is 0.
- Stall in IDLE: acceptance still allowed.
- Reset mid-RUN: the instruction is abandoned and no `seq_done` is raised.

## Timing
- Reset values: state IDLE, group 0, exec 0, tag 0. All outputs are 0, including `issue_ready` while `rst` is high. `issue_ready = 1` from the first cycle after reset.
- Accept in cycle T → slice 0 is presented in T+1.
- With exec active up to slice k and no stalls, the instruction occupies RUN for k+1 cycles and `seq_done` fires in T+1+k.
- Back-to-back: the next instruction is accepted in the `seq_done` cycle, so its slice 0 is presented the following cycle with zero bubbles.
- Throughput: one slice per non-stalled cycle.
- Outputs depend combinationally only on state registers and `alu_stall`/`issue_valid`. There are no input-to-strobe paths except through `issue_ready`.

## Structure
- Shared package `alu_seq_pkg`: `NUM_GROUPS = 4`, `GROUP_LANES = 16`, `WF_LANES = 64`, and the state encoding (IDLE = 0, RUN = 1).
- Sub-module `exec_group_scan`: combinational. Takes the 64-bit exec and group, and produces `act[3:0]`, `act[group]` and `more`. The sequencer FSM and registers sit in the top module.

## Test plan
- Exec `FFFF_FFFF_FFFF_FFFF`, no stall → wr_en at T, then shift_en at T+1..T+3, `alu_group` 0,1,2,3, first at T+1, last and `seq_done` at T+4.
- Exec `0000_0000_FFFF_0000` → group 0 with valid=0, group 1 with valid=1 and first=last=1, `seq_done` at T+2, exactly one shift_en.
- Exec all zero → single RUN cycle with valid=0, `seq_done` at T+1, no shift_en.
- Two full-exec instructions offered continuously → second accepted in the first's `seq_done` cycle, wr_en that cycle with no shift, and 8 contiguous valid slices with tags switching at slice 4.
- `alu_stall` high for 3 cycles at group 1 → outputs frozen, no strobes, `issue_ready` = 0; the sequence then resumes and `seq_done` is delayed by exactly 3 cycles.
- `rst` asserted at group 2 → next cycle IDLE, all outputs 0, no `seq_done`; a new issue is accepted the cycle after `rst` deasserts.
